// File: rtl/fc_train_sequencer_if.sv
// Command, start/done handshake and 1R1W parameter-update bus of the FC layer sequencer.
// master = sequencer side, slave = host / datapath / memory side.
interface fc_train_sequencer_if #(
    parameter int AW = 11
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_train;
    logic [3:0]         lr_shift;
    logic               fwd_start;
    logic               fwd_done;
    logic               bwd_start;
    logic               bwd_done;
    logic               upd_rd_en;
    logic [AW-1:0]      upd_raddr;
    logic signed [15:0] w_rdata;
    logic signed [15:0] g_rdata;
    logic               upd_wr_en;
    logic [AW-1:0]      upd_waddr;
    logic [15:0]        upd_wdata;

    modport master (
        input  cmd_valid, cmd_train, lr_shift, fwd_done, bwd_done, w_rdata, g_rdata,
        output cmd_ready, fwd_start, bwd_start, upd_rd_en, upd_raddr,
               upd_wr_en, upd_waddr, upd_wdata
    );

    modport slave (
        output cmd_valid, cmd_train, lr_shift, fwd_done, bwd_done, w_rdata, g_rdata,
        input  cmd_ready, fwd_start, bwd_start, upd_rd_en, upd_raddr,
               upd_wr_en, upd_waddr, upd_wdata
    );
endinterface

// File: rtl/fc_train_sequencer.sv
// Sequences one FC layer through forward (and backward + in-place SGD update in train mode),
// owning the sub-unit start/done handshakes and a completion watchdog.
module fc_train_sequencer #(
    parameter int INPUT_SIZE  = 120,
    parameter int OUTPUT_SIZE = 10,
    parameter int TIMEOUT     = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fc_train_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int N_P = INPUT_SIZE * OUTPUT_SIZE + OUTPUT_SIZE;
    localparam int AW  = $clog2(N_P);
    localparam int KW  = $clog2(N_P + 1);
    localparam int WW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, FWD_START, FWD_WAIT, BWD_START, BWD_WAIT, UPD, FINISH
    } state_t;

    state_t          state, next;
    logic            train_q;
    logic [3:0]      lr_q;
    logic            fwd_done_q, bwd_done_q;
    logic [WW-1:0]   wd;
    logic [KW-1:0]   k;
    logic            wr_en_q;
    logic [AW-1:0]   waddr_q;

    logic            accept, timeout, rd_en;
    logic            fwd_rise, bwd_rise, wd_hit;
    logic signed [15:0] g_sh;
    logic [16:0]     diff;
    logic [15:0]     sat;

    assign fwd_rise = bus.fwd_done & ~fwd_done_q;
    assign bwd_rise = bus.bwd_done & ~bwd_done_q;
    assign wd_hit   = (wd == WW'(TIMEOUT - 1));
    assign rd_en    = (state == UPD) && (k != KW'(N_P));

    always_comb begin
        next    = state;
        accept  = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: if (bus.cmd_valid) begin
                accept = 1'b1;
                next   = FWD_START;
            end
            FWD_START: next = FWD_WAIT;
            FWD_WAIT: begin
                if (fwd_rise) next = train_q ? BWD_START : FINISH;
                else if (wd_hit) begin
                    timeout = 1'b1;
                    next    = FINISH;
                end
            end
            BWD_START: next = BWD_WAIT;
            BWD_WAIT: begin
                if (bwd_rise) next = UPD;
                else if (wd_hit) begin
                    timeout = 1'b1;
                    next    = FINISH;
                end
            end
            // k == N_P is the drain cycle that carries the last trailing write
            UPD: if (k == KW'(N_P)) next = FINISH;
            FINISH: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            train_q    <= 1'b0;
            lr_q       <= '0;
            error      <= 1'b0;
            fwd_done_q <= 1'b0;
            bwd_done_q <= 1'b0;
            wd         <= '0;
            k          <= '0;
            wr_en_q    <= 1'b0;
            waddr_q    <= '0;
        end else begin
            state      <= next;
            fwd_done_q <= bus.fwd_done;
            bwd_done_q <= bus.bwd_done;
            if (accept) begin
                train_q <= bus.cmd_train;
                lr_q    <= bus.lr_shift;
                error   <= 1'b0;
            end else if (timeout) begin
                error <= 1'b1;
            end
            if (state == FWD_WAIT || state == BWD_WAIT) wd <= wd + WW'(1);
            else                                         wd <= '0;
            if (state != UPD) k <= '0;
            else if (rd_en)   k <= k + KW'(1);
            wr_en_q <= rd_en;
            waddr_q <= k[AW-1:0];
        end
    end

    // Read data arrives the cycle after the read, aligned with the trailing write
    always_comb begin
        g_sh = bus.g_rdata >>> lr_q;
        diff = {bus.w_rdata[15], bus.w_rdata} - {g_sh[15], g_sh};
        if (diff[16] != diff[15]) sat = diff[16] ? 16'h8000 : 16'h7fff;
        else                      sat = diff[15:0];
    end

    assign bus.cmd_ready = rst_n & (state == IDLE);
    assign bus.fwd_start = (state == FWD_START);
    assign bus.bwd_start = (state == BWD_START);
    assign bus.upd_rd_en = rd_en;
    assign bus.upd_raddr = k[AW-1:0];
    assign bus.upd_wr_en = wr_en_q;
    assign bus.upd_waddr = waddr_q;
    assign bus.upd_wdata = wr_en_q ? sat : '0;
    assign busy          = (state != IDLE);
    assign done          = (state == FINISH);
endmodule

// File: doc/fc_train_sequencer.md
# fc_train_sequencer

Control block that sequences one fully-connected layer through inference or a full training step. It accepts a command from the host controller and pulses start into the forward unit, and in training mode also into the backward unit. After backward completes it runs an in-place SGD update over the layer's weight and bias memory through a 1R1W port. It sits between the network-level controller and the FullyConnect forward/backward datapaths, and owns their start/done handshakes and a completion watchdog.

## Interface
- INPUT_SIZE, 120, layer input count
- OUTPUT_SIZE, 10, layer output count
- TIMEOUT, 65535, max cycles to wait for a sub-unit done
- N_P (localparam), INPUT_SIZE*OUTPUT_SIZE+OUTPUT_SIZE, parameter-space size; addresses 0..N_W-1 are weights (N_W=INPUT_SIZE*OUTPUT_SIZE), N_W..N_P-1 are biases
- AW (localparam), $clog2(N_P), update address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_train  in  1  1 = training step, 0 = inference; captured on accept
- lr_shift  in  4  learning-rate shift; captured on accept
- fwd_start  out  1  one-cycle pulse to forward unit
- fwd_done  in  1  forward done; level, may stay high between runs
- bwd_start  out  1  one-cycle pulse to backward unit
- bwd_done  in  1  backward done; level
- upd_rd_en  out  1  read strobe for param/grad memories
- upd_raddr  out  AW  read address
- w_rdata  in  16  signed param, valid the cycle after upd_rd_en
- g_rdata  in  16  signed gradient, valid the cycle after upd_rd_en
- upd_wr_en  out  1  write strobe
- upd_waddr  out  AW  write address
- upd_wdata  out  16  updated param
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  sticky timeout flag; cleared on next command accept

## Operation
- States: IDLE, FWD_START, FWD_WAIT, BWD_START, BWD_WAIT, UPD, FINISH.
- IDLE: when cmd_valid && cmd_ready, latch cmd_train and lr_shift, clear error, and go to FWD_START.
- FWD_START: assert fwd_start for 1 cycle, clear the watchdog, and go to FWD_WAIT.
- FWD_WAIT: on a rising edge of fwd_done (fwd_done && !fwd_done_q), go to BWD_START if in train mode, otherwise FINISH.
- BWD_START and BWD_WAIT behave the same way with bwd_start/bwd_done. A bwd_done rise goes to UPD.
- Done edges are detected through a registered copy of each done signal. A level held high from a previous run never counts as completion.
- Watchdog: counts cycles in *_WAIT. When the count reaches TIMEOUT without a rise, set error=1 and go to FINISH; no update is performed.
- UPD: read index k runs 0..N_P-1, one read per cycle. In the cycle after each read, write upd_waddr = k_prev and upd_wdata = sat16(w - (g >>> lr_shift)).
  - The shift is arithmetic.
  - The subtraction is computed at 17 bits, then saturated to [-32768, 32767].
- UPD exit: after the last read, one drain cycle issues the final write, then go to FINISH.
- FINISH: pulse done for 1 cycle, then go to IDLE.
- Reset (any state, including mid-UPD): state=IDLE and all outputs 0. The pending write is discarded, and the edge registers and watchdog are cleared.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first post-reset IDLE cycle; all other outputs 0.
- Command accepted in cycle T: fwd_start is high in T+1.
- Rise on fwd_done in cycle D (inference): done high in D+1, cmd_ready high in D+2.
- Training: bwd_start one cycle after the fwd_done rise.
  - The first upd_rd_en comes one cycle after the bwd_done rise.
  - UPD lasts N_P+1 cycles: N_P reads, with writes trailing reads by exactly one cycle.
  - done is high the cycle after the last write.
- Read of k+1 and write of k occur in the same cycle on different addresses; the memory must be 1R1W.
- fwd_start and bwd_start are never high together and never high for more than 1 cycle.
- Done signals are ignored outside their *_WAIT state. cmd_valid is ignored while busy.

## Test plan
- Inference:
  - Stimulus: cmd_train=0; model forward raises fwd_done 20 cycles after start.
  - Required: one fwd_start; no bwd_start or upd_*; done 1 cycle after the rise; error=0.
- Training, INPUT_SIZE=3, OUTPUT_SIZE=2 (N_P=8):
  - Stimulus: params=100, grads=32, lr_shift=4.
  - Required: 8 writes at addresses 0..7, each data 98; done the cycle after waddr=7.
- Saturation:
  - Stimulus: w=0x7FF0, g=0x8000, lr_shift=0 → upd_wdata=0x7FFF. Also w=0x8005, g=0x0010 → 0x8000.
  - Stimulus: g=-1, shift 15.
  - Required: that write is w+1.
- Stale done:
  - Stimulus: fwd_done held high before the command, dropping 2 cycles after fwd_start and rising again 10 cycles later.
  - Required: the sequencer advances only on the second rise.
- Timeout, TIMEOUT=16:
  - Stimulus: bwd_done never rises.
  - Required: error=1 and done pulse 16 cycles into BWD_WAIT, with no upd_wr_en; the next accepted command clears error.
- Reset mid-UPD:
  - Stimulus: rst_n low at k=3.
  - Required: all outputs 0 immediately; after release, IDLE with cmd_ready=1 and no write issued.
